// File: rtl/vec_pkg.sv
// Shared types, constants and helpers for the perspective-divide stage.
//   fixed_t   : signed Q8.8 word
//   vec4_t    : {x, y, z, w} vertex from the matrix multiplier
//   vec3_t    : {x/w, y/w, z/w} normalized result
//   state_e   : control FSM states
//   abs_mag   : two's-complement magnitude (0x8000 -> 32768)
//   fix_result: sign, saturation and divide-by-zero handling of a quotient
package vec_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned DVD_W     = WIDTH + FRAC_BITS;
  localparam int unsigned CNT_W     = 5;

  typedef logic signed [WIDTH-1:0] fixed_t;
  typedef fixed_t vec4_t[4];
  typedef fixed_t vec3_t[3];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam fixed_t FIXED_MAX = 16'h7FFF;
  localparam fixed_t FIXED_MIN = 16'h8000;

  // Largest quotient magnitudes that fit a positive / negative result.
  localparam logic [DVD_W-1:0] POS_LIMIT = DVD_W'(32'h0000_7FFF);
  localparam logic [DVD_W-1:0] NEG_LIMIT = DVD_W'(32'h0000_8000);

  // Magnitude as unsigned; the most negative value maps to 32768.
  function automatic logic [WIDTH-1:0] abs_mag(input fixed_t a);
    logic [WIDTH-1:0] mag;
    mag = a[WIDTH-1] ? WIDTH'(-a) : WIDTH'(a);
    return mag;
  endfunction

  // Turn an unsigned quotient magnitude into the signed, saturated result.
  function automatic fixed_t fix_result(input logic [DVD_W-1:0] q,
                                        input logic             neg,
                                        input logic             dz,
                                        input logic             a_neg);
    fixed_t res;
    if (dz) begin
      res = a_neg ? FIXED_MIN : FIXED_MAX;
    end else if (!neg) begin
      res = (q > POS_LIMIT) ? FIXED_MAX : fixed_t'(q[WIDTH-1:0]);
    end else begin
      res = (q > NEG_LIMIT) ? FIXED_MIN : fixed_t'(WIDTH'(-q[WIDTH-1:0]));
    end
    return res;
  endfunction

endpackage

// File: rtl/perspective_divide_udiv.sv
// Unsigned restoring divider, one quotient bit per step (24-bit / 16-bit).
//   Clk, Reset : clock and synchronous active-high reset
//   load       : capture dividend/divisor and clear the partial remainder
//   step       : perform one restoring step (MSB first)
//   dividend   : 24-bit unsigned dividend
//   divisor    : 16-bit unsigned divisor
//   quotient   : 24-bit quotient, final after 24 steps following load
module seq_udiv_24by16
  import vec_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [DVD_W-1:0] quotient
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DVD_W-1:0] r_dq;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_div_ext;
  logic             w_fits;

  assign w_trial   = {r_rem, r_dq[DVD_W-1]};
  assign w_div_ext = {1'b0, r_divisor};
  assign w_fits    = (w_trial >= w_div_ext);

  // Remainder stays below the divisor, so 16 bits always hold it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rem     <= '0;
      r_divisor <= '0;
      r_dq      <= '0;
    end else if (load) begin
      r_rem     <= '0;
      r_divisor <= divisor;
      r_dq      <= dividend;
    end else if (step) begin
      r_rem <= w_fits ? WIDTH'(w_trial - w_div_ext) : w_trial[WIDTH-1:0];
      r_dq  <= {r_dq[DVD_W-2:0], w_fits};
    end
  end

  assign quotient = r_dq;

endmodule

// File: rtl/perspective_divide.sv
// Divides x, y, z of a Q8.8 vertex by w using one shared serial divider.
//   Clk, Reset : clock and synchronous active-high reset
//   in_valid   : ivector holds a vertex        in_ready  : vertex accepted
//   ivector    : {x, y, z, w} signed Q8.8
//   out_valid  : ovector holds a result        out_ready : result consumed
//   ovector    : {x/w, y/w, z/w} signed Q8.8, saturated
//   div_zero   : w was zero for the presented result
module perspective_divide
  import vec_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  vec4_t ivector,
  output logic  out_valid,
  input  logic  out_ready,
  output vec3_t ovector,
  output logic  div_zero
);

  state_e             r_state;
  state_e             w_state_nxt;
  vec4_t              r_vec;
  vec3_t              r_ovector;
  logic [1:0]         r_comp;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_div_zero;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic [1:0]         w_comp_nxt;
  fixed_t             w_num;
  fixed_t             w_den;
  logic [DVD_W-1:0]   w_dividend;
  logic [DVD_W-1:0]   w_quot;
  logic               w_dz;
  fixed_t             w_result;

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        w_step = 1'b1;
        if (r_bit_cnt == '0) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_fix = 1'b1;
        if (r_comp == 2'd2) begin
          w_state_nxt = DONE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands come straight from the inputs on acceptance, else from the latch.
  assign w_comp_nxt = r_comp + 2'd1;
  assign w_num      = w_accept ? ivector[0] : r_vec[w_comp_nxt];
  assign w_den      = w_accept ? ivector[3] : r_vec[3];
  assign w_dividend = DVD_W'(abs_mag(w_num)) << FRAC_BITS;

  seq_udiv_24by16 u_udiv (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (w_load),
    .step     (w_step),
    .dividend (w_dividend),
    .divisor  (abs_mag(w_den)),
    .quotient (w_quot)
  );

  assign w_dz     = (r_vec[3] == '0);
  assign w_result = fix_result(w_quot,
                               r_vec[r_comp][WIDTH-1] ^ r_vec[3][WIDTH-1],
                               w_dz,
                               r_vec[r_comp][WIDTH-1]);

  // State, handshake flags, latched vertex and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_div_zero  <= 1'b0;
      r_comp      <= '0;
      r_bit_cnt   <= '0;
      for (int i = 0; i < 3; i++) r_ovector[i] <= '0;
      for (int i = 0; i < 4; i++) r_vec[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_vec  <= ivector;
        r_comp <= '0;
      end
      if (w_load) begin
        r_bit_cnt <= CNT_W'(DVD_W - 1);
      end else if (w_step) begin
        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
      end
      if (w_fix) begin
        r_ovector[r_comp] <= w_result;
        r_comp            <= w_comp_nxt;
        if (r_comp == 2'd2) begin
          r_div_zero <= w_dz;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ovector   = r_ovector;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_perspective_divide.sv
module tb_perspective_divide;
  import vec_pkg::*;

  logic   Clk;
  logic   Reset;
  logic   in_valid;
  logic   in_ready;
  fixed_t ivector [4];
  logic   out_valid;
  logic   out_ready;
  fixed_t ovector [3];
  logic   div_zero;

  perspective_divide dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ivector   (ivector),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovector   (ovector),
    .div_zero  (div_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [47:0] ov;
    logic        dz;
    logic [31:0] acc;
  } exp_t;

  exp_t        sq[$];
  int unsigned cyc;
  int unsigned last_acc;
  int unsigned last_hs;
  int          n_chk;
  int          n_fail;
  logic        prev_v;

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; prev_v = 1'b0; last_acc = 0; last_hs = 0;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, payload and stall
  // behaviour on every valid cycle, pop on handshake.
  always @(negedge Clk) begin
    if (!Reset && out_valid) begin
      if (sq.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!prev_v) chk("latency", 64'(cyc - sq[0].acc), 64'd75);
        chk("ovector", 64'({ovector[0], ovector[1], ovector[2]}), 64'(sq[0].ov));
        chk("div_zero", 64'(div_zero), 64'(sq[0].dz));
        chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(sq.pop_front());
          last_hs = cyc + 1;
        end
      end
    end
    prev_v = out_valid;
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [15:0] w,
                      input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic dz);
    int   n;
    exp_t e;
    n = 0;
    @(negedge Clk);
    in_valid   = 1'b1;
    ivector[0] = x; ivector[1] = y; ivector[2] = z; ivector[3] = w;
    while (!in_ready && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
    end else begin
      e.ov  = {e0, e1, e2};
      e.dz  = dz;
      e.acc = cyc + 1;
      last_acc = cyc + 1;
      sq.push_back(e);
      @(posedge Clk);
    end
  endtask

  // Drop in_valid and scramble the inputs; the DUT must use its latched copy.
  task automatic idle_inputs();
    @(negedge Clk);
    in_valid   = 1'b0;
    ivector[0] = 16'hDEAD; ivector[1] = 16'hBEEF;
    ivector[2] = 16'h1234; ivector[3] = 16'h0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sq.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_empty", 64'(sq.size()), 64'd0);
    sq.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ovector"}, 64'({ovector[0], ovector[1], ovector[2]}), 64'd0);
    chk({tag, "_div_zero"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ivector[i] = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset_state("reset");
    Reset = 1'b0;

    // Simple divide
    send(16'h0200, 16'h0100, 16'h0000, 16'h0200, 16'h0100, 16'h0080, 16'h0000, 1'b0);
    idle_inputs(); drain();
    // Truncation toward zero and signs
    send(16'h0100, 16'hFF00, 16'hFF00, 16'h0300, 16'h0055, 16'hFFAB, 16'hFFAB, 1'b0);
    idle_inputs(); drain();
    // Negative divisor
    send(16'h0100, 16'h0000, 16'h0000, 16'hFE00, 16'hFF80, 16'h0000, 16'h0000, 1'b0);
    idle_inputs(); drain();
    // Saturation
    send(16'h7F00, 16'h8000, 16'h0040, 16'h0040, 16'h7FFF, 16'h8000, 16'h0100, 1'b0);
    idle_inputs(); drain();
    // Exact -32768 result is not saturated
    send(16'h8000, 16'h7FFF, 16'h0001, 16'h0100, 16'h8000, 16'h7FFF, 16'h0001, 1'b0);
    idle_inputs(); drain();
    // Divide by -1: +32768 saturates to 0x7FFF
    send(16'h8000, 16'h0001, 16'hFFFF, 16'hFF00, 16'h7FFF, 16'hFFFF, 16'h0001, 1'b0);
    idle_inputs(); drain();
    // Divide by zero
    send(16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b1);
    idle_inputs(); drain();

    // Backpressure with a second vertex waiting on the input
    out_ready = 1'b0;
    send(16'h0300, 16'hFD00, 16'h0080, 16'h0100, 16'h0300, 16'hFD00, 16'h0080, 1'b0);
    fork
      send(16'h0100, 16'h0100, 16'h0100, 16'h8000, 16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b0);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge Clk);
          n++;
        end
        repeat (10) @(negedge Clk);
        @(posedge Clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("accept_after_handshake", 64'(last_acc), 64'(last_hs + 1));
    idle_inputs(); drain();

    // Reset at edge 30 after acceptance drops the in-flight vertex
    send(16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    idle_inputs();
    while (cyc < last_acc + 29) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    sq.delete();
    chk_reset_state("midop_reset");
    Reset = 1'b0;
    send(16'hFF00, 16'h0080, 16'h0400, 16'h0100, 16'hFF00, 16'h0080, 16'h0400, 1'b0);
    idle_inputs(); drain();

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
